pipe_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline (IF, ID, EXE, MEM, WB).
- Owns the per-stage valid bits that feed each stage's X_valid input, including EXE_valid.
- Generates allow-in handshakes, inter-stage bus latch enables and the fetch-advance strobe.
- Stalls ID on RAW hazards; no forwarding is implemented. Flushes the pipe on a WB-raised cancel (exception, eret).

---
 rtl/pipe_ctrl_if.sv | 49 ++++
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline sequencer and its five stages.
// master: the sequencer (pipe_ctrl); slave: the stage datapaths.
interface pipe_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              IF_over;
  logic              ID_over;
  logic              EXE_over;
  logic              MEM_over;
  logic              WB_over;
  logic [REG_AW-1:0] ID_rs;
  logic [REG_AW-1:0] ID_rt;
  logic              ID_rs_used;
  logic              ID_rt_used;
  logic [REG_AW-1:0] EXE_wdest;
  logic [REG_AW-1:0] MEM_wdest;
  logic [REG_AW-1:0] WB_wdest;
  logic              cancel;

  logic              IF_valid;
  logic              ID_valid;
  logic              EXE_valid;
  logic              MEM_valid;
  logic              WB_valid;
  logic              IF_ID_en;
  logic              ID_EXE_en;
  logic              EXE_MEM_en;
  logic              MEM_WB_en;
  logic              next_fetch;
  logic              data_hazard;

  modport master (
    input  IF_over, ID_over, EXE_over, MEM_over, WB_over,
    input  ID_rs, ID_rt, ID_rs_used, ID_rt_used,
    input  EXE_wdest, MEM_wdest, WB_wdest, cancel,
    output IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
    output IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
    output next_fetch, data_hazard
  );

  modport slave (
    output IF_over, ID_over, EXE_over, MEM_over, WB_over,
    output ID_rs, ID_rt, ID_rs_used, ID_rt_used,
    output EXE_wdest, MEM_wdest, WB_wdest, cancel,
    input  IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid,
    input  IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
    input  next_fetch, data_hazard
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stage valids, allow-in chain, latch enables, RAW stall, flush.
// Optional macro PIPE_PERF_CNT_EN adds retired-instruction and ID-stall counters.
module pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  pipe_ctrl_if.master bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_retired,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  if (REG_AW < 1 || PERF_W < 1) begin : g_param_check
    $error("pipe_ctrl: REG_AW and PERF_W must be at least 1");
  end

  logic r_if_valid;
  logic r_id_valid;
  logic r_exe_valid;
  logic r_mem_valid;
  logic r_wb_valid;

  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_hazard;

  logic w_if_go;
  logic w_id_go;
  logic w_exe_go;
  logic w_mem_go;

  logic w_wb_allow_in;
  logic w_mem_allow_in;
  logic w_exe_allow_in;
  logic w_id_allow_in;

  logic w_if_adv;
  logic w_id_adv;
  logic w_exe_adv;
  logic w_mem_adv;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign w_rs = bus.ID_rs;
  assign w_rt = bus.ID_rt;
  assign w_rs_hit = bus.ID_rs_used && (w_rs != '0) &&
                    ((w_rs == bus.EXE_wdest) || (w_rs == bus.MEM_wdest) || (w_rs == bus.WB_wdest));
  assign w_rt_hit = bus.ID_rt_used && (w_rt != '0) &&
                    ((w_rt == bus.EXE_wdest) || (w_rt == bus.MEM_wdest) || (w_rt == bus.WB_wdest));
  assign w_hazard = r_id_valid && (w_rs_hit || w_rt_hit);

  assign w_if_go  = r_if_valid  && bus.IF_over;
  assign w_id_go  = r_id_valid  && bus.ID_over && !w_hazard;
  assign w_exe_go = r_exe_valid && bus.EXE_over;
  assign w_mem_go = r_mem_valid && bus.MEM_over;

  // Backpressure ripples from WB towards IF within the same cycle.
  assign w_wb_allow_in  = !r_wb_valid  || bus.WB_over;
  assign w_mem_allow_in = !r_mem_valid || (bus.MEM_over && w_wb_allow_in);
  assign w_exe_allow_in = !r_exe_valid || (bus.EXE_over && w_mem_allow_in);
  assign w_id_allow_in  = !r_id_valid  || (bus.ID_over && !w_hazard && w_exe_allow_in);

  assign w_if_adv  = w_if_go  && w_id_allow_in;
  assign w_id_adv  = w_id_go  && w_exe_allow_in;
  assign w_exe_adv = w_exe_go && w_mem_allow_in;
  assign w_mem_adv = w_mem_go && w_wb_allow_in;

  // A flush suppresses every bus latch so no stale data moves down the pipe.
  assign bus.IF_ID_en   = w_if_adv  && !bus.cancel;
  assign bus.ID_EXE_en  = w_id_adv  && !bus.cancel;
  assign bus.EXE_MEM_en = w_exe_adv && !bus.cancel;
  assign bus.MEM_WB_en  = w_mem_adv && !bus.cancel;
  assign bus.next_fetch = resetn && (bus.IF_ID_en || bus.cancel);
  assign bus.data_hazard = w_hazard;

  assign bus.IF_valid  = r_if_valid;
  assign bus.ID_valid  = r_id_valid;
  assign bus.EXE_valid = r_exe_valid;
  assign bus.MEM_valid = r_mem_valid;
  assign bus.WB_valid  = r_wb_valid;

  // A stage that accepts but receives nothing from its predecessor turns into a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_valid  <= 1'b0;
      r_id_valid  <= 1'b0;
      r_exe_valid <= 1'b0;
      r_mem_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b1;
      if (bus.cancel) begin
        r_id_valid  <= 1'b0;
        r_exe_valid <= 1'b0;
        r_mem_valid <= 1'b0;
        r_wb_valid  <= 1'b0;
      end else begin
        if (w_id_allow_in)  r_id_valid  <= w_if_adv;
        if (w_exe_allow_in) r_exe_valid <= w_id_adv;
        if (w_mem_allow_in) r_mem_valid <= w_exe_adv;
        if (w_wb_allow_in)  r_wb_valid  <= w_mem_adv;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_retired;
  logic [PERF_W-1:0] r_perf_stall;

  // Counters wrap naturally on overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_retired <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (r_wb_valid && bus.WB_over && !bus.cancel) r_perf_retired <= r_perf_retired + 1'b1;
      if (r_id_valid && !w_id_allow_in)             r_perf_stall   <= r_perf_stall + 1'b1;
    end
  end

  assign perf_retired = r_perf_retired;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a slot-occupancy pipeline model predicts each cycle's outputs.
// Define PIPE_PERF_CNT_EN to also check the performance counters.
module tb_pipe_ctrl;
  localparam int REG_AW = 5;
  localparam int PERF_W = 32;
  localparam int NSIG   = 11;

  typedef struct {
    logic [NSIG-1:0]   sig;
    logic [PERF_W-1:0] retired;
    logic [PERF_W-1:0] stalls;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  pipe_ctrl_if #(.REG_AW(REG_AW)) bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] perfRetired;
  logic [PERF_W-1:0] perfStall;
`endif

  pipe_ctrl #(.REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_retired (perfRetired),
    .perf_stall   (perfStall)
`endif
  );

  always #5 clk = ~clk;

  exp_t  expQ[$];
  int    checks = 0;
  int    errors = 0;
  string sigName[NSIG] = '{"IF_valid", "ID_valid", "EXE_valid", "MEM_valid", "WB_valid",
                           "IF_ID_en", "ID_EXE_en", "EXE_MEM_en", "MEM_WB_en",
                           "next_fetch", "data_hazard"};

  // Model: slot s (0=IF..4=WB) holds an instruction when occ[s]; each carries dest/sources.
  bit          occ[5], nOcc[5];
  int unsigned dst[5], srcS[5], srcT[5];
  int unsigned nDst[5], nSrcS[5], nSrcT[5];
  bit          useS[5], useT[5], nUseS[5], nUseT[5];
  logic [PERF_W-1:0] mRet = '0, mStl = '0, nRet = '0, nStl = '0;
  bit          hazardFree = 1'b1;

  task automatic makeInstr(output int unsigned d, output int unsigned s, output int unsigned t,
                           output bit us, output bit ut);
    d  = $urandom_range(0, 7);
    s  = $urandom_range(0, 7);
    t  = $urandom_range(0, 7);
    us = hazardFree ? 1'b0 : 1'($urandom_range(0, 1));
    ut = hazardFree ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  // An older instruction still in EXE/MEM/WB that writes the register blocks the read.
  function automatic bit regHit(input bit used, input int unsigned r);
    bit hit = 1'b0;
    if (used && r != 0)
      for (int s = 2; s < 5; s++)
        if (occ[s] && dst[s] == r) hit = 1'b1;
    return hit;
  endfunction

  task automatic commitModel();
    for (int s = 0; s < 5; s++) begin
      occ[s]  = nOcc[s];
      dst[s]  = nDst[s];
      srcS[s] = nSrcS[s];
      srcT[s] = nSrcT[s];
      useS[s] = nUseS[s];
      useT[s] = nUseT[s];
    end
    mRet = nRet;
    mStl = nStl;
  endtask

  task automatic checkOutput(input string name, input logic [PERF_W-1:0] act,
                             input logic [PERF_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, predicts the outputs and the model state after the next edge.
  task automatic applyStimulus(input bit rst, input bit [4:0] over, input bit cancelIn);
    bit   hz;
    bit   done[5], accept[5], leave[5];
    exp_t e;
    resetn = rst;
    if (!rst) begin
      for (int s = 0; s < 5; s++) occ[s] = 1'b0;
      mRet = '0;
      mStl = '0;
    end
    bus.IF_over    = over[0];
    bus.ID_over    = over[1];
    bus.EXE_over   = over[2];
    bus.MEM_over   = over[3];
    bus.WB_over    = over[4];
    bus.cancel     = cancelIn;
    bus.ID_rs      = REG_AW'(srcS[1]);
    bus.ID_rt      = REG_AW'(srcT[1]);
    bus.ID_rs_used = useS[1];
    bus.ID_rt_used = useT[1];
    bus.EXE_wdest  = occ[2] ? REG_AW'(dst[2]) : '0;
    bus.MEM_wdest  = occ[3] ? REG_AW'(dst[3]) : '0;
    bus.WB_wdest   = occ[4] ? REG_AW'(dst[4]) : '0;

    hz = occ[1] && (regHit(useS[1], srcS[1]) || regHit(useT[1], srcT[1]));
    for (int s = 0; s < 5; s++) done[s] = occ[s] && over[s] && !(s == 1 && hz);
    for (int s = 4; s >= 0; s--) begin
      leave[s]  = done[s] && (s == 4 || accept[s+1]);
      accept[s] = !occ[s] || leave[s];
    end

    for (int s = 0; s < 5; s++) e.sig[s] = occ[s];
    for (int s = 0; s < 4; s++) e.sig[5+s] = rst && !cancelIn && leave[s];
    e.sig[9]  = rst && (cancelIn || leave[0]);
    e.sig[10] = hz;
    e.retired = mRet;
    e.stalls  = mStl;
    expQ.push_back(e);

    for (int s = 0; s < 5; s++) begin
      nOcc[s]  = occ[s];
      nDst[s]  = dst[s];
      nSrcS[s] = srcS[s];
      nSrcT[s] = srcT[s];
      nUseS[s] = useS[s];
      nUseT[s] = useT[s];
    end
    if (!rst) begin
      for (int s = 0; s < 5; s++) nOcc[s] = 1'b0;
      nRet = '0;
      nStl = '0;
    end else begin
      nRet = mRet + PERF_W'(occ[4] && over[4] && !cancelIn);
      nStl = mStl + PERF_W'(occ[1] && !accept[1]);
      if (cancelIn) begin
        for (int s = 1; s < 5; s++) nOcc[s] = 1'b0;
        makeInstr(nDst[0], nSrcS[0], nSrcT[0], nUseS[0], nUseT[0]);
      end else begin
        for (int s = 4; s >= 1; s--)
          if (accept[s]) begin
            nOcc[s]  = leave[s-1];
            nDst[s]  = dst[s-1];
            nSrcS[s] = srcS[s-1];
            nSrcT[s] = srcT[s-1];
            nUseS[s] = useS[s-1];
            nUseT[s] = useT[s-1];
          end
        if (leave[0]) makeInstr(nDst[0], nSrcS[0], nSrcT[0], nUseS[0], nUseT[0]);
      end
      nOcc[0] = 1'b1;
    end
  endtask

  task automatic stepCycle(input bit rst, input bit [4:0] over, input bit cancelIn);
    @(posedge clk);
    commitModel();
    #1;
    applyStimulus(rst, over, cancelIn);
  endtask

  function automatic bit [4:0] randOver();
    bit [4:0] o;
    for (int i = 0; i < 5; i++) o[i] = ($urandom_range(0, 3) != 0);
    return o;
  endfunction

  // Monitor: every cycle the DUT presents a full output set, compared against the oldest prediction.
  initial begin
    exp_t e;
    logic [NSIG-1:0] act;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        act = {bus.data_hazard, bus.next_fetch, bus.MEM_WB_en, bus.EXE_MEM_en, bus.ID_EXE_en,
               bus.IF_ID_en, bus.WB_valid, bus.MEM_valid, bus.EXE_valid, bus.ID_valid, bus.IF_valid};
        for (int i = 0; i < NSIG; i++) checkOutput(sigName[i], PERF_W'(act[i]), PERF_W'(e.sig[i]));
`ifdef PIPE_PERF_CNT_EN
        checkOutput("perf_retired", perfRetired, e.retired);
        checkOutput("perf_stall", perfStall, e.stalls);
`endif
      end
    end
  end

  initial begin
    bus.IF_over = 1'b0; bus.ID_over = 1'b0; bus.EXE_over = 1'b0;
    bus.MEM_over = 1'b0; bus.WB_over = 1'b0; bus.cancel = 1'b0;
    bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_rs_used = 1'b0; bus.ID_rt_used = 1'b0;
    bus.EXE_wdest = '0; bus.MEM_wdest = '0; bus.WB_wdest = '0;

    // Held in reset with noisy inputs, including cancel.
    for (int i = 0; i < 3; i++) stepCycle(1'b0, randOver(), 1'($urandom_range(0, 1)));

    // Release and fill with a hazard-free stream.
    for (int i = 0; i < 10; i++) stepCycle(1'b1, 5'b11111, 1'b0);

    // Multiplier stall in EXE for three cycles, then resume.
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 5'b11011, 1'b0);
    for (int i = 0; i < 4; i++) stepCycle(1'b1, 5'b11111, 1'b0);

    // Flush a full pipe.
    stepCycle(1'b1, 5'b11111, 1'b1);
    for (int i = 0; i < 6; i++) stepCycle(1'b1, 5'b11111, 1'b0);

    // Flush while EXE is stalled.
    for (int i = 0; i < 2; i++) stepCycle(1'b1, 5'b11011, 1'b0);
    stepCycle(1'b1, 5'b11011, 1'b1);
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 5'b11111, 1'b0);

    // Dependent instructions with all stages ready: RAW stalls only.
    hazardFree = 1'b0;
    for (int i = 0; i < 40; i++) stepCycle(1'b1, 5'b11111, 1'b0);

    // Fully random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) stepCycle(1'b1, randOver(), ($urandom_range(0, 31) == 0));

    // Asynchronous reset in the middle of traffic, then continue.
    for (int i = 0; i < 2; i++) stepCycle(1'b0, randOver(), 1'b0);
    for (int i = 0; i < 200; i++) stepCycle(1'b1, randOver(), ($urandom_range(0, 31) == 0));

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", PERF_W'(expQ.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
